sys_cmd_ctrl: RTL

SYS_CMD_CTRL -- requirements
Module: sys_cmd_ctrl

---
 rtl/sys_pkg.sv | 28 ++
 rtl/sys_cmd_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/sys_pkg.sv
// Shared definitions for the system command controller: command opcodes,
// fixed ALU operand addresses and the controller FSM state encoding.
package sys_pkg;

  localparam logic [7:0] CmdRegWr   = 8'hAA;
  localparam logic [7:0] CmdRegRd   = 8'hBB;
  localparam logic [7:0] CmdAluOp   = 8'hCC;
  localparam logic [7:0] CmdAluNoOp = 8'hDD;

  localparam int unsigned OpAAddr = 0;
  localparam int unsigned OpBAddr = 1;

  typedef enum logic [3:0] {
    StIdle,
    StWrAddr,
    StWrData,
    StRdAddr,
    StRdWait,
    StRdSend,
    StOpA,
    StOpB,
    StFun,
    StAluWait,
    StSendLo,
    StSendHi
  } sys_state_e;

endpackage

// File: rtl/sys_cmd_ctrl.sv
// UART command controller: decodes RX frames into register-file and ALU
// operations and serializes read data / ALU results into the TX FIFO.
module sys_cmd_ctrl
  import sys_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned FUN_WIDTH  = 4
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [DATA_WIDTH-1:0]   RX_P_DATA,
  input  logic                    RX_D_VLD,
  input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
  input  logic                    ALU_OUT_VLD,
  input  logic [DATA_WIDTH-1:0]   RdData,
  input  logic                    RdData_VLD,
  input  logic                    FIFO_FULL,
  output logic                    ALU_EN,
  output logic [FUN_WIDTH-1:0]    ALU_FUN,
  output logic                    CLK_EN,
  output logic [ADDR_WIDTH-1:0]   Address,
  output logic                    WrEn,
  output logic                    RdEn,
  output logic [DATA_WIDTH-1:0]   WrData,
  output logic [DATA_WIDTH-1:0]   TX_P_DATA,
  output logic                    TX_D_VLD
);

  sys_state_e state_q, state_d;

  logic                    alu_en_q,    alu_en_d;
  logic [FUN_WIDTH-1:0]    alu_fun_q,   alu_fun_d;
  logic                    clk_en_q,    clk_en_d;
  logic [ADDR_WIDTH-1:0]   addr_q,      addr_d;
  logic                    wr_en_q,     wr_en_d;
  logic                    rd_en_q,     rd_en_d;
  logic [DATA_WIDTH-1:0]   wr_data_q,   wr_data_d;
  logic [DATA_WIDTH-1:0]   tx_data_q,   tx_data_d;
  logic                    tx_vld_q,    tx_vld_d;
  logic [DATA_WIDTH-1:0]   rd_byte_q,   rd_byte_d;
  logic [2*DATA_WIDTH-1:0] alu_res_q,   alu_res_d;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= StIdle;
      alu_en_q  <= 1'b0;
      alu_fun_q <= '0;
      clk_en_q  <= 1'b0;
      addr_q    <= '0;
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      wr_data_q <= '0;
      tx_data_q <= '0;
      tx_vld_q  <= 1'b0;
      rd_byte_q <= '0;
      alu_res_q <= '0;
    end else begin
      state_q   <= state_d;
      alu_en_q  <= alu_en_d;
      alu_fun_q <= alu_fun_d;
      clk_en_q  <= clk_en_d;
      addr_q    <= addr_d;
      wr_en_q   <= wr_en_d;
      rd_en_q   <= rd_en_d;
      wr_data_q <= wr_data_d;
      tx_data_q <= tx_data_d;
      tx_vld_q  <= tx_vld_d;
      rd_byte_q <= rd_byte_d;
      alu_res_q <= alu_res_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    alu_en_d  = 1'b0;
    alu_fun_d = alu_fun_q;
    addr_d    = addr_q;
    wr_en_d   = 1'b0;
    rd_en_d   = 1'b0;
    wr_data_d = wr_data_q;
    tx_data_d = tx_data_q;
    tx_vld_d  = 1'b0;
    rd_byte_d = rd_byte_q;
    alu_res_d = alu_res_q;

    unique case (state_q)
      StIdle: begin
        if (RX_D_VLD) begin
          case (RX_P_DATA)
            DATA_WIDTH'(CmdRegWr):   state_d = StWrAddr;
            DATA_WIDTH'(CmdRegRd):   state_d = StRdAddr;
            DATA_WIDTH'(CmdAluOp):   state_d = StOpA;
            DATA_WIDTH'(CmdAluNoOp): state_d = StFun;
            default:                 state_d = StIdle;
          endcase
        end
      end
      StWrAddr: begin
        if (RX_D_VLD) begin
          addr_d  = RX_P_DATA[ADDR_WIDTH-1:0];
          state_d = StWrData;
        end
      end
      StWrData: begin
        if (RX_D_VLD) begin
          wr_en_d   = 1'b1;
          wr_data_d = RX_P_DATA;
          state_d   = StIdle;
        end
      end
      StRdAddr: begin
        if (RX_D_VLD) begin
          addr_d  = RX_P_DATA[ADDR_WIDTH-1:0];
          rd_en_d = 1'b1;
          state_d = StRdWait;
        end
      end
      StRdWait: begin
        // Push straight from the read return when possible so the TX byte
        // lands one cycle after RdData_VLD; otherwise park in StRdSend.
        if (RdData_VLD) begin
          rd_byte_d = RdData;
          if (!FIFO_FULL) begin
            tx_vld_d  = 1'b1;
            tx_data_d = RdData;
            state_d   = StIdle;
          end else begin
            state_d = StRdSend;
          end
        end
      end
      StRdSend: begin
        if (!FIFO_FULL) begin
          tx_vld_d  = 1'b1;
          tx_data_d = rd_byte_q;
          state_d   = StIdle;
        end
      end
      StOpA: begin
        if (RX_D_VLD) begin
          addr_d    = ADDR_WIDTH'(OpAAddr);
          wr_data_d = RX_P_DATA;
          wr_en_d   = 1'b1;
          state_d   = StOpB;
        end
      end
      StOpB: begin
        if (RX_D_VLD) begin
          addr_d    = ADDR_WIDTH'(OpBAddr);
          wr_data_d = RX_P_DATA;
          wr_en_d   = 1'b1;
          state_d   = StFun;
        end
      end
      StFun: begin
        if (RX_D_VLD) begin
          alu_fun_d = RX_P_DATA[FUN_WIDTH-1:0];
          alu_en_d  = 1'b1;
          state_d   = StAluWait;
        end
      end
      StAluWait: begin
        // Same early-push shortcut as reads: StSendLo is only visited when
        // the FIFO is full at the moment the result arrives.
        if (ALU_OUT_VLD) begin
          alu_res_d = ALU_OUT;
          if (!FIFO_FULL) begin
            tx_vld_d  = 1'b1;
            tx_data_d = ALU_OUT[DATA_WIDTH-1:0];
            state_d   = StSendHi;
          end else begin
            state_d = StSendLo;
          end
        end
      end
      StSendLo: begin
        if (!FIFO_FULL) begin
          tx_vld_d  = 1'b1;
          tx_data_d = alu_res_q[DATA_WIDTH-1:0];
          state_d   = StSendHi;
        end
      end
      StSendHi: begin
        if (!FIFO_FULL) begin
          tx_vld_d  = 1'b1;
          tx_data_d = alu_res_q[2*DATA_WIDTH-1:DATA_WIDTH];
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    clk_en_d = (state_d == StFun) || (state_d == StAluWait);
  end

  assign ALU_EN    = alu_en_q;
  assign ALU_FUN   = alu_fun_q;
  assign CLK_EN    = clk_en_q;
  assign Address   = addr_q;
  assign WrEn      = wr_en_q;
  assign RdEn      = rd_en_q;
  assign WrData    = wr_data_q;
  assign TX_P_DATA = tx_data_q;
  assign TX_D_VLD  = tx_vld_q;

endmodule
